gmii_rx_framer: RTL and testbench
=================================

GMII_RX_FRAMER -- requirements
Module: gmii_rx_framer

Interface
REQ-001 SHALL have parameter MAX_FRAME_LEN, default 1518, max accepted byte count from destination MAC through FCS.
REQ-002 SHALL have port gmii_rxc  in  1  receive byte clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports gmii_rx_dv / gmii_rx_er  in  1 / 1  GMII receive valid / error.
REQ-005 SHALL have port gmii_rxd  in  8  GMII receive byte.
REQ-006 SHALL have port link_up  in  1  in-band link status.
REQ-007 SHALL have port rx_frame_start  out  1  one-cycle pulse when the SFD is accepted.
REQ-008 SHALL have ports rx_frame_data_valid / rx_frame_data  out  1 / 8  frame byte stream with FCS stripped.
REQ-009 SHALL have ports rx_frame_done / rx_frame_drop  out  1 / 1  one-cycle pulse, frame good / frame bad.

Function
REQ-010 SHALL implement states IDLE, PREAMBLE, DATA, DROP.
REQ-011 IDLE->PREAMBLE SHALL occur on gmii_rx_dv=1 with link_up=1 and gmii_rxd=0x55; dv=1 with any other byte SHALL go to DROP.
REQ-012 PREAMBLE SHALL stay on 0x55, go to DATA on 0xD5 with a rx_frame_start pulse the next cycle, and go to DROP on any other byte or on gmii_rx_er.
REQ-013 dv falling in PREAMBLE SHALL return to IDLE with no start, done or drop pulse.
REQ-014 DATA SHALL push each byte into a 4-byte delay line; once 4 or more bytes are held, each new byte SHALL emit the oldest byte on rx_frame_data with rx_frame_data_valid=1 one cycle later, so the final 4 bytes (FCS) are never emitted.
REQ-015 DATA SHALL count bytes in a 12-bit counter that saturates at 4095.
REQ-016 DATA SHALL run a CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) over every byte after the SFD, FCS included.
REQ-017 On dv falling in DATA, exactly one of rx_frame_done / rx_frame_drop SHALL pulse the next cycle, then the state SHALL return to IDLE.
REQ-018 rx_frame_drop SHALL be chosen if count < 64, count > MAX_FRAME_LEN, gmii_rx_er was seen in DATA, or the CRC check fails (REQ-027).
REQ-019 link_up falling in DATA SHALL pulse rx_frame_drop the next cycle and enter DROP.
REQ-020 DROP SHALL ignore input until gmii_rx_dv=0, then go to IDLE; it SHALL pulse rx_frame_drop only when entered from DATA.
REQ-021 Every rx_frame_start SHALL be followed by exactly one done or drop pulse before the next start.
REQ-022 Back-to-back frames with a 1-cycle dv-low gap SHALL each be processed correctly.
REQ-023 rx_frame_data SHALL hold its last value while rx_frame_data_valid=0.

Reset
REQ-024 rst_n low SHALL asynchronously force state IDLE; all outputs, the counter and the delay line to 0; CRC to 0xFFFFFFFF.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no done or drop pulse; after release, the first dv-high byte with no preceding dv-low cycle SHALL be treated as DROP until dv falls.

Configuration
REQ-026 Macro GMII_RX_CRC_CHECK_EN SHALL gate CRC checking.
REQ-027 With the macro defined, a frame whose final CRC residue is not 0xDEBB20E3 (equivalently, complemented residue ≠ 0x2144DF1C) SHALL be dropped.
REQ-028 Without the macro, the CRC logic SHALL be omitted and the FCS still stripped; only length, error and link conditions SHALL cause a drop.

Verification
REQ-029 7x0x55, 0xD5, a 60-byte payload 0x00..0x3B, and a valid FCS -> one start pulse, 60 valid bytes 0x00..0x3B in order, one done pulse, no drop.
REQ-030 The same frame with payload byte 10 flipped to 0xFF -> 60 valid bytes, then rx_frame_drop (macro defined) or rx_frame_done (macro undefined).
REQ-031 A frame of 40 payload bytes plus valid FCS (44 total) -> 40 valid bytes, then rx_frame_drop.
REQ-032 gmii_rx_er=1 for one cycle at payload byte 20 of a good 100-byte frame -> rx_frame_drop, no done.
REQ-033 Preamble 0x55,0x55,0x57 -> no start, state DROP until dv falls, then a following good frame -> done.
REQ-034 rst_n pulsed low at payload byte 30 -> all outputs 0 immediately, no done or drop; the next full good frame -> done.

Source files
------------

// File: rtl/gmii_rx_framer_if.sv
// rtl/gmii_rx_framer_if.sv - GMII receive inputs and framed byte-stream outputs
`timescale 1ns/1ps
interface gmii_rx_framer_if;
  logic       gmii_rx_dv;
  logic       gmii_rx_er;
  logic [7:0] gmii_rxd;
  logic       link_up;
  logic       rx_frame_start;
  logic       rx_frame_data_valid;
  logic [7:0] rx_frame_data;
  logic       rx_frame_done;
  logic       rx_frame_drop;

  modport master (
    output gmii_rx_dv, gmii_rx_er, gmii_rxd, link_up,
    input  rx_frame_start, rx_frame_data_valid, rx_frame_data, rx_frame_done, rx_frame_drop
  );

  modport slave (
    input  gmii_rx_dv, gmii_rx_er, gmii_rxd, link_up,
    output rx_frame_start, rx_frame_data_valid, rx_frame_data, rx_frame_done, rx_frame_drop
  );
endinterface

// File: rtl/gmii_rx_framer.sv
// rtl/gmii_rx_framer.sv - GMII receive framer: preamble/SFD detect, FCS strip, good/bad frame verdict
// Define GMII_RX_CRC_CHECK_EN to drop frames whose CRC-32 residue is wrong.
`timescale 1ns/1ps
module gmii_rx_framer #(
  parameter int MAX_FRAME_LEN = 1518
) (
  input logic             gmii_rxc,
  input logic             rst_n,
  gmii_rx_framer_if.slave rx
);
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  localparam logic [7:0]  PRE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE = 8'hD5;
  localparam logic [11:0] MIN_LEN  = 12'd64;
  localparam logic [11:0] MAX_LEN  = 12'(MAX_FRAME_LEN);
  localparam logic [11:0] CNT_SAT  = 12'hFFF;

  state_t          state;
  logic [3:0][7:0] dly;
  logic [11:0]     byte_cnt;
  logic            er_seen;
  logic            dv_low_seen;
  logic            crc_bad;

`ifdef GMII_RX_CRC_CHECK_EN
  logic [31:0] crc;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Running the CRC across the FCS too leaves a fixed residue for an intact frame.
  assign crc_bad = (crc != 32'hDEBB20E3);
`else
  assign crc_bad = 1'b0;
`endif

  always_ff @(posedge gmii_rxc or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= IDLE;
      dly                    <= '0;
      byte_cnt               <= '0;
      er_seen                <= 1'b0;
      dv_low_seen            <= 1'b0;
      rx.rx_frame_start      <= 1'b0;
      rx.rx_frame_data_valid <= 1'b0;
      rx.rx_frame_data       <= '0;
      rx.rx_frame_done       <= 1'b0;
      rx.rx_frame_drop       <= 1'b0;
`ifdef GMII_RX_CRC_CHECK_EN
      crc                    <= 32'hFFFFFFFF;
`endif
    end else begin
      rx.rx_frame_start      <= 1'b0;
      rx.rx_frame_data_valid <= 1'b0;
      rx.rx_frame_done       <= 1'b0;
      rx.rx_frame_drop       <= 1'b0;
      // A frame already in flight when reset lifts must not be picked up mid-stream.
      if (!rx.gmii_rx_dv)
        dv_low_seen <= 1'b1;

      case (state)
        IDLE: begin
          if (rx.gmii_rx_dv) begin
            if (dv_low_seen && rx.link_up && rx.gmii_rxd == PRE_BYTE)
              state <= PREAMBLE;
            else
              state <= DROP;
          end
        end

        PREAMBLE: begin
          if (!rx.gmii_rx_dv) begin
            state <= IDLE;
          end else if (rx.gmii_rx_er || (rx.gmii_rxd != PRE_BYTE && rx.gmii_rxd != SFD_BYTE)) begin
            state <= DROP;
          end else if (rx.gmii_rxd == SFD_BYTE) begin
            state             <= DATA;
            rx.rx_frame_start <= 1'b1;
            byte_cnt          <= '0;
            er_seen           <= 1'b0;
`ifdef GMII_RX_CRC_CHECK_EN
            crc               <= 32'hFFFFFFFF;
`endif
          end
        end

        DATA: begin
          if (!rx.gmii_rx_dv) begin
            if (byte_cnt < MIN_LEN || byte_cnt > MAX_LEN || er_seen || crc_bad)
              rx.rx_frame_drop <= 1'b1;
            else
              rx.rx_frame_done <= 1'b1;
            state <= IDLE;
          end else if (!rx.link_up) begin
            rx.rx_frame_drop <= 1'b1;
            state            <= DROP;
          end else begin
            // Four bytes stay behind in the delay line so the FCS is never emitted.
            dly <= {dly[2:0], rx.gmii_rxd};
            if (byte_cnt != CNT_SAT)
              byte_cnt <= byte_cnt + 12'd1;
            if (byte_cnt >= 12'd4) begin
              rx.rx_frame_data       <= dly[3];
              rx.rx_frame_data_valid <= 1'b1;
            end
            if (rx.gmii_rx_er)
              er_seen <= 1'b1;
`ifdef GMII_RX_CRC_CHECK_EN
            crc <= crc32_byte(crc, rx.gmii_rxd);
`endif
          end
        end

        DROP: begin
          if (!rx.gmii_rx_dv)
            state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gmii_rx_framer.sv
// tb/tb_gmii_rx_framer.sv - randomized and directed self-checking bench for gmii_rx_framer
`timescale 1ns/1ps
module tb_gmii_rx_framer;
  typedef logic [7:0] bq_t[$];

  localparam int MAX_LEN  = 1518;
  localparam int EV_START = 256;
  localparam int EV_DONE  = 512;
  localparam int EV_DROP  = 768;

  logic gmii_rxc = 1'b0;
  logic rst_n    = 1'b0;

  gmii_rx_framer_if bus();

  gmii_rx_framer #(.MAX_FRAME_LEN(MAX_LEN)) dut (
    .gmii_rxc (gmii_rxc),
    .rst_n    (rst_n),
    .rx       (bus)
  );

  always #4 gmii_rxc = ~gmii_rxc;

  int         checks   = 0;
  int         failures = 0;
  int         exp_q[$];
  logic [7:0] last_data = 8'h00;
  int         n_start = 0, n_valid = 0, n_done = 0, n_drop = 0;
  int         s_start, s_valid, s_done, s_drop;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input string name, input int act);
    int e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s unexpected actual=0x%0h required=none", name, act);
    end else begin
      e = exp_q.pop_front();
      if (e != act) begin
        failures++;
        $display("FAIL %s actual=0x%0h required=0x%0h", name, act, e);
      end
    end
  endtask

  function automatic logic [31:0] crc32(input bq_t b, input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, b[i]};
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t incr_payload(input int n);
    bq_t p;
    for (int i = 0; i < n; i++) p.push_back(8'(i));
    return p;
  endfunction

  function automatic bq_t rand_payload(input int n);
    bq_t p;
    for (int i = 0; i < n; i++) p.push_back(8'($urandom_range(0, 255)));
    return p;
  endfunction

  function automatic bq_t build_frame(input bq_t p, input bit bad_fcs);
    bq_t f;
    logic [31:0] c;
    for (int i = 0; i < 7; i++) f.push_back(8'h55);
    f.push_back(8'hD5);
    foreach (p[i]) f.push_back(p[i]);
    c = crc32(p, p.size());
    if (bad_fcs) c = c ^ 32'h1;
    for (int k = 0; k < 4; k++) f.push_back(c[8*k +: 8]);
    return f;
  endfunction

  // Expected output events for one dv-high burst, derived from the frame rules.
  task automatic model_frame(input bq_t b, input int er_at, input int link_at);
    bq_t data;
    int  i;
    bit  er_seen;
    bit  bad;
    bit  crc_ok;
    int  n;
    er_seen = 1'b0;
    if (b.size() == 0 || b[0] != 8'h55) return;
    i = 1;
    while (i < b.size() && b[i] == 8'h55 && i != er_at) i++;
    if (i >= b.size() || b[i] != 8'hD5 || i == er_at) return;
    exp_q.push_back(EV_START);
    for (int j = i + 1; j < b.size(); j++) begin
      if (j == link_at) begin
        for (int k = 0; k < int'(data.size()) - 4; k++) exp_q.push_back(int'(data[k]));
        exp_q.push_back(EV_DROP);
        return;
      end
      data.push_back(b[j]);
      if (j == er_at) er_seen = 1'b1;
    end
    n = data.size();
    for (int k = 0; k < n - 4; k++) exp_q.push_back(int'(data[k]));
    crc_ok = (n >= 4) && (crc32(data, n - 4) == {data[n-1], data[n-2], data[n-3], data[n-4]});
    bad = (n < 64) || (n > MAX_LEN) || er_seen;
`ifdef GMII_RX_CRC_CHECK_EN
    bad = bad || !crc_ok;
`endif
    exp_q.push_back(bad ? EV_DROP : EV_DONE);
  endtask

  task automatic send(input bq_t f, input int er_at, input int link_at, input int rst_at, input int gap);
    model_frame(f, er_at, link_at);
    foreach (f[i]) begin
      @(posedge gmii_rxc); #1;
      bus.gmii_rx_dv = 1'b1;
      bus.gmii_rxd   = f[i];
      bus.gmii_rx_er = (i == er_at);
      bus.link_up    = !(link_at >= 0 && i >= link_at);
      rst_n          = (i != rst_at);
    end
    for (int g = 0; g < gap; g++) begin
      @(posedge gmii_rxc); #1;
      bus.gmii_rx_dv = 1'b0;
      bus.gmii_rx_er = 1'b0;
      bus.gmii_rxd   = 8'h00;
      bus.link_up    = 1'b1;
      rst_n          = 1'b1;
    end
  endtask

  task automatic snap();
    s_start = n_start; s_valid = n_valid; s_done = n_done; s_drop = n_drop;
  endtask

  always @(negedge gmii_rxc) begin
    if (!rst_n) begin
      check("rst_start", bus.rx_frame_start, 0);
      check("rst_valid", bus.rx_frame_data_valid, 0);
      check("rst_data",  bus.rx_frame_data, 0);
      check("rst_done",  bus.rx_frame_done, 0);
      check("rst_drop",  bus.rx_frame_drop, 0);
      exp_q.delete();
      last_data = 8'h00;
    end else begin
      if (bus.rx_frame_start) begin n_start++; expect_ev("start", EV_START); end
      if (bus.rx_frame_data_valid) begin
        n_valid++;
        expect_ev("data", int'(bus.rx_frame_data));
        last_data = bus.rx_frame_data;
      end else begin
        check("data_hold", bus.rx_frame_data, last_data);
      end
      if (bus.rx_frame_done) begin n_done++; expect_ev("done", EV_DONE); end
      if (bus.rx_frame_drop) begin n_drop++; expect_ev("drop", EV_DROP); end
    end
  end

  initial begin
    bq_t f, p, s;
    int  len, er_at, link_at;

    bus.gmii_rx_dv = 1'b0;
    bus.gmii_rx_er = 1'b0;
    bus.gmii_rxd   = 8'h00;
    bus.link_up    = 1'b1;
    repeat (5) @(posedge gmii_rxc);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge gmii_rxc);

    for (int i = 0; i < 9; i++) s.push_back(8'h31 + 8'(i));
    check("crc_model_pin", crc32(s, 9), 32'hCBF43926);

    // Good minimum-size frame.
    snap();
    send(build_frame(incr_payload(60), 1'b0), -1, -1, -1, 4);
    check("good_start", n_start - s_start, 1);
    check("good_valid", n_valid - s_valid, 60);
    check("good_done",  n_done - s_done, 1);
    check("good_drop",  n_drop - s_drop, 0);

    // Corrupted payload byte.
    snap();
    f = build_frame(incr_payload(60), 1'b0);
    f[18] = 8'hFF;
    send(f, -1, -1, -1, 4);
    check("crcerr_valid", n_valid - s_valid, 60);
`ifdef GMII_RX_CRC_CHECK_EN
    check("crcerr_drop", n_drop - s_drop, 1);
`else
    check("crcerr_done", n_done - s_done, 1);
`endif

    // Runt frame.
    snap();
    send(build_frame(incr_payload(40), 1'b0), -1, -1, -1, 4);
    check("runt_valid", n_valid - s_valid, 40);
    check("runt_drop",  n_drop - s_drop, 1);

    // Receive error inside the payload.
    snap();
    send(build_frame(incr_payload(100), 1'b0), 8 + 20, -1, -1, 4);
    check("rxer_drop", n_drop - s_drop, 1);
    check("rxer_done", n_done - s_done, 0);

    // Bad preamble, then a good frame.
    snap();
    f = '{8'h55, 8'h55, 8'h57, 8'hD5, 8'h01, 8'h02};
    send(f, -1, -1, -1, 1);
    send(build_frame(incr_payload(60), 1'b0), -1, -1, -1, 4);
    check("badpre_start", n_start - s_start, 1);
    check("badpre_done",  n_done - s_done, 1);
    check("badpre_drop",  n_drop - s_drop, 0);

    // Reset mid-frame, then a good frame.
    snap();
    send(build_frame(incr_payload(60), 1'b0), -1, -1, 8 + 30, 3);
    check("rst_mid_done", n_done - s_done, 0);
    check("rst_mid_drop", n_drop - s_drop, 0);
    snap();
    send(build_frame(incr_payload(60), 1'b0), -1, -1, -1, 4);
    check("after_rst_done", n_done - s_done, 1);

    // Link loss mid-frame.
    snap();
    send(build_frame(incr_payload(80), 1'b0), -1, 8 + 50, -1, 4);
    check("link_valid", n_valid - s_valid, 46);
    check("link_drop",  n_drop - s_drop, 1);

    // Length limits.
    snap();
    send(build_frame(rand_payload(MAX_LEN - 4), 1'b0), -1, -1, -1, 4);
    check("maxlen_done", n_done - s_done, 1);
    snap();
    send(build_frame(rand_payload(MAX_LEN - 3), 1'b0), -1, -1, -1, 4);
    check("oversize_drop", n_drop - s_drop, 1);

    // Back-to-back frames with a single dv-low cycle.
    snap();
    for (int i = 0; i < 3; i++) send(build_frame(rand_payload(64), 1'b0), -1, -1, -1, 1);
    repeat (3) @(posedge gmii_rxc);
    check("b2b_done", n_done - s_done, 3);

    // Randomized mix.
    for (int t = 0; t < 25; t++) begin
      len = $urandom_range(40, 120);
      p = rand_payload(len);
      f = build_frame(p, $urandom_range(0, 3) == 0);
      er_at = -1;
      link_at = -1;
      case ($urandom_range(0, 9))
        0: er_at = 8 + $urandom_range(0, len + 3);
        1: link_at = 8 + $urandom_range(0, len + 3);
        2: f[$urandom_range(1, 6)] = 8'h57;
        3: er_at = $urandom_range(1, 7);
        default: ;
      endcase
      send(f, er_at, link_at, -1, $urandom_range(1, 3));
    end

    repeat (10) @(posedge gmii_rxc);
    check("exp_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
